// File: rtl/calib_pulse_seq.sv
// calib_pulse_seq: arbitrated single-shot/burst calibration pulse generator with delayed trigger requests
module calib_pulse_seq #(
    parameter int NPLS_W = 12,
    parameter int DLY_W  = 8
) (
    input  logic              CLK40,
    input  logic              RST_RESYNC,
    input  logic              TTC_INJ,
    input  logic              TTC_EXT,
    input  logic              SW_START,
    input  logic              SW_ABORT,
    input  logic              SW_SEL,
    input  logic [NPLS_W-1:0] BURST_LEN,
    input  logic [3:0]        PLS_WIDTH,
    input  logic [DLY_W-1:0]  PLS_GAP,
    input  logic [DLY_W-1:0]  TRG_DLY,
    output logic              INJ_PULSE,
    output logic              EXT_PULSE,
    output logic              TRG_REQ,
    output logic              BUSY,
    output logic              DONE,
    output logic              TRG_OVR,
    output logic              REQ_DROP,
    output logic [NPLS_W-1:0] PLS_SENT
);
    typedef enum logic [1:0] {IDLE, PULSE, GAP, DRAIN} state_t;
    state_t state;
    logic [NPLS_W-1:0] target, start_len, sent_nxt;
    logic [3:0] w_lat, pcnt, w_in;
    logic [DLY_W-1:0] g_lat, d_lat, gcnt, tcnt, d_use, g_in;
    logic sel_inj, abort, any_req, accept, start_sel, pls_start;
    assign BUSY = state != IDLE;
    always_comb begin
        abort     = SW_ABORT && state != IDLE;
        any_req   = TTC_INJ || TTC_EXT || SW_START;
        accept    = state == IDLE && !SW_ABORT && (TTC_INJ || TTC_EXT || (SW_START && BURST_LEN != '0));
        start_sel = TTC_INJ ? 1'b1 : TTC_EXT ? 1'b0 : SW_SEL;
        start_len = (TTC_INJ || TTC_EXT) ? NPLS_W'(1) : BURST_LEN;
        w_in      = PLS_WIDTH == 4'd0 ? 4'd1 : PLS_WIDTH;
        g_in      = PLS_GAP == '0 ? DLY_W'(1) : PLS_GAP;
        pls_start = accept || (!abort && state == GAP && gcnt == DLY_W'(1));
        d_use     = state == IDLE ? TRG_DLY : d_lat;
        sent_nxt  = &PLS_SENT ? PLS_SENT : PLS_SENT + NPLS_W'(1);
    end
    always_ff @(posedge CLK40 or posedge RST_RESYNC) begin
        if (RST_RESYNC) begin
            state     <= IDLE;
            INJ_PULSE <= 1'b0;
            EXT_PULSE <= 1'b0;
            TRG_REQ   <= 1'b0;
            DONE      <= 1'b0;
            TRG_OVR   <= 1'b0;
            REQ_DROP  <= 1'b0;
            PLS_SENT  <= '0;
            target    <= '0;
            sel_inj   <= 1'b0;
            w_lat     <= 4'd1;
            pcnt      <= '0;
            g_lat     <= DLY_W'(1);
            d_lat     <= '0;
            gcnt      <= '0;
            tcnt      <= '0;
        end else begin
            REQ_DROP <= any_req && !(accept && $onehot({TTC_INJ, TTC_EXT, SW_START}));
            DONE     <= 1'b0;
            // single delay counter: a pending trigger wins over a newer pulse's trigger
            TRG_REQ  <= !abort && (tcnt == DLY_W'(1) || (pls_start && tcnt == '0 && d_use == '0));
            TRG_OVR  <= !abort && pls_start && tcnt != '0;
            tcnt     <= abort ? '0 : (pls_start && tcnt == '0) ? d_use : (tcnt != '0 ? tcnt - DLY_W'(1) : '0);
            if (abort) begin
                state     <= IDLE;
                INJ_PULSE <= 1'b0;
                EXT_PULSE <= 1'b0;
            end else if (accept) begin
                state     <= PULSE;
                target    <= start_len;
                sel_inj   <= start_sel;
                w_lat     <= w_in;
                g_lat     <= g_in;
                d_lat     <= TRG_DLY;
                pcnt      <= w_in;
                PLS_SENT  <= '0;
                INJ_PULSE <= start_sel;
                EXT_PULSE <= !start_sel;
            end else if (state == PULSE && pcnt == 4'd1) begin
                PLS_SENT  <= sent_nxt;
                INJ_PULSE <= 1'b0;
                EXT_PULSE <= 1'b0;
                gcnt      <= g_lat;
                state     <= sent_nxt == target ? DRAIN : GAP;
            end else if (state == PULSE) begin
                pcnt <= pcnt - 4'd1;
            end else if (state == GAP && gcnt == DLY_W'(1)) begin
                state     <= PULSE;
                pcnt      <= w_lat;
                INJ_PULSE <= sel_inj;
                EXT_PULSE <= !sel_inj;
            end else if (state == GAP) begin
                gcnt <= gcnt - DLY_W'(1);
            end else if (state == DRAIN && tcnt == '0) begin
                state <= IDLE;
                DONE  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_calib_pulse_seq.sv
// tb_calib_pulse_seq: directed scenario bench; bit i of each log is the output in cycle i after the strobe cycle
module tb_calib_pulse_seq;
    logic CLK40 = 1'b0, RST_RESYNC, TTC_INJ, TTC_EXT, SW_START, SW_ABORT, SW_SEL;
    logic [11:0] BURST_LEN, PLS_SENT;
    logic [3:0] PLS_WIDTH;
    logic [7:0] PLS_GAP, TRG_DLY;
    logic INJ_PULSE, EXT_PULSE, TRG_REQ, BUSY, DONE, TRG_OVR, REQ_DROP;
    logic [31:0] inj_l, ext_l, trg_l, done_l, ovr_l, drop_l, busy_l;
    int tests = 0, fails = 0;

    calib_pulse_seq #(.NPLS_W(12), .DLY_W(8)) dut (
        .CLK40(CLK40), .RST_RESYNC(RST_RESYNC), .TTC_INJ(TTC_INJ), .TTC_EXT(TTC_EXT),
        .SW_START(SW_START), .SW_ABORT(SW_ABORT), .SW_SEL(SW_SEL), .BURST_LEN(BURST_LEN),
        .PLS_WIDTH(PLS_WIDTH), .PLS_GAP(PLS_GAP), .TRG_DLY(TRG_DLY), .INJ_PULSE(INJ_PULSE),
        .EXT_PULSE(EXT_PULSE), .TRG_REQ(TRG_REQ), .BUSY(BUSY), .DONE(DONE), .TRG_OVR(TRG_OVR),
        .REQ_DROP(REQ_DROP), .PLS_SENT(PLS_SENT)
    );

    always #5 CLK40 = ~CLK40;

    task automatic go(input logic inj, input logic ext, input logic sw, input logic abt, input int n);
        TTC_INJ = inj; TTC_EXT = ext; SW_START = sw; SW_ABORT = abt;
        {inj_l, ext_l, trg_l, done_l, ovr_l, drop_l, busy_l} = '0;
        for (int i = 1; i <= n; i++) begin
            @(posedge CLK40); #1;
            TTC_INJ = 0; TTC_EXT = 0; SW_START = 0; SW_ABORT = 0;
            inj_l[i] = INJ_PULSE; ext_l[i] = EXT_PULSE; trg_l[i] = TRG_REQ; done_l[i] = DONE;
            ovr_l[i] = TRG_OVR; drop_l[i] = REQ_DROP; busy_l[i] = BUSY;
        end
    endtask

    task automatic test_reset;
        RST_RESYNC = 1; {TTC_INJ, TTC_EXT, SW_START, SW_ABORT, SW_SEL} = '0;
        BURST_LEN = 0; PLS_WIDTH = 0; PLS_GAP = 0; TRG_DLY = 0;
        #1;
        tests++; if ({INJ_PULSE, EXT_PULSE, TRG_REQ, BUSY, DONE, TRG_OVR, REQ_DROP} !== 7'b0) begin fails++; $display("FAIL reset_outs: got %b want 0000000", {INJ_PULSE, EXT_PULSE, TRG_REQ, BUSY, DONE, TRG_OVR, REQ_DROP}); end
        tests++; if (PLS_SENT !== 12'd0) begin fails++; $display("FAIL reset_sent: got %0d want 0", PLS_SENT); end
        repeat (2) @(posedge CLK40);
        #1 RST_RESYNC = 0;
    endtask

    task automatic test_single;
        PLS_WIDTH = 2; TRG_DLY = 5;
        go(1, 0, 0, 0, 10);
        tests++; if (inj_l !== 32'h6) begin fails++; $display("FAIL single_inj: got %h want 00000006", inj_l); end
        tests++; if (ext_l !== 32'h0) begin fails++; $display("FAIL single_ext: got %h want 00000000", ext_l); end
        tests++; if (trg_l !== 32'h40) begin fails++; $display("FAIL single_trg: got %h want 00000040", trg_l); end
        tests++; if (done_l !== 32'h80) begin fails++; $display("FAIL single_done: got %h want 00000080", done_l); end
        tests++; if (busy_l !== 32'h7E) begin fails++; $display("FAIL single_busy: got %h want 0000007e", busy_l); end
        tests++; if (PLS_SENT !== 12'd1) begin fails++; $display("FAIL single_sent: got %0d want 1", PLS_SENT); end
    endtask

    task automatic test_burst;
        SW_SEL = 0; BURST_LEN = 3; PLS_WIDTH = 1; PLS_GAP = 4; TRG_DLY = 2;
        go(0, 0, 1, 0, 16);
        tests++; if (ext_l !== 32'h842) begin fails++; $display("FAIL burst_ext: got %h want 00000842", ext_l); end
        tests++; if (inj_l !== 32'h0) begin fails++; $display("FAIL burst_inj: got %h want 00000000", inj_l); end
        tests++; if (trg_l !== 32'h2108) begin fails++; $display("FAIL burst_trg: got %h want 00002108", trg_l); end
        tests++; if (done_l !== 32'h4000) begin fails++; $display("FAIL burst_done: got %h want 00004000", done_l); end
        tests++; if (PLS_SENT !== 12'd3) begin fails++; $display("FAIL burst_sent: got %0d want 3", PLS_SENT); end
    endtask

    task automatic test_arbitration;
        PLS_WIDTH = 1; TRG_DLY = 0; BURST_LEN = 5;
        go(1, 1, 1, 0, 1);
        tests++; if (inj_l !== 32'h2 || ext_l !== 32'h0) begin fails++; $display("FAIL arb_lines: got inj %h ext %h want 00000002 00000000", inj_l, ext_l); end
        tests++; if (drop_l !== 32'h2) begin fails++; $display("FAIL arb_drop: got %h want 00000002", drop_l); end
        tests++; if (trg_l !== 32'h2) begin fails++; $display("FAIL arb_trg0: got %h want 00000002", trg_l); end
        go(0, 1, 0, 0, 4);
        tests++; if (drop_l !== 32'h2) begin fails++; $display("FAIL busy_drop: got %h want 00000002", drop_l); end
        tests++; if (ext_l !== 32'h0 || done_l !== 32'h4) begin fails++; $display("FAIL busy_done: got ext %h done %h want 00000000 00000004", ext_l, done_l); end
        tests++; if (PLS_SENT !== 12'd1) begin fails++; $display("FAIL arb_sent: got %0d want 1", PLS_SENT); end
    endtask

    task automatic test_trg_overrun;
        SW_SEL = 1; BURST_LEN = 4; PLS_WIDTH = 1; PLS_GAP = 1; TRG_DLY = 3;
        go(0, 0, 1, 0, 14);
        tests++; if (inj_l !== 32'hAA) begin fails++; $display("FAIL ovr_inj: got %h want 000000aa", inj_l); end
        tests++; if (trg_l !== 32'h110) begin fails++; $display("FAIL ovr_trg: got %h want 00000110", trg_l); end
        tests++; if (ovr_l !== 32'h88) begin fails++; $display("FAIL ovr_flag: got %h want 00000088", ovr_l); end
        tests++; if (done_l !== 32'h200) begin fails++; $display("FAIL ovr_done: got %h want 00000200", done_l); end
    endtask

    task automatic test_clamp;
        SW_SEL = 0; BURST_LEN = 2; PLS_WIDTH = 0; PLS_GAP = 0; TRG_DLY = 0;
        go(0, 0, 1, 0, 8);
        tests++; if (ext_l !== 32'hA || trg_l !== 32'hA) begin fails++; $display("FAIL clamp_lines: got ext %h trg %h want 0000000a 0000000a", ext_l, trg_l); end
        tests++; if (done_l !== 32'h20) begin fails++; $display("FAIL clamp_done: got %h want 00000020", done_l); end
    endtask

    task automatic test_abort;
        SW_SEL = 1; BURST_LEN = 5; PLS_WIDTH = 2; PLS_GAP = 2; TRG_DLY = 1;
        go(0, 0, 1, 0, 5);
        PLS_WIDTH = 9; TRG_DLY = 0;
        tests++; if (inj_l !== 32'h26 || trg_l !== 32'h4) begin fails++; $display("FAIL abort_pre: got inj %h trg %h want 00000026 00000004", inj_l, trg_l); end
        go(0, 0, 0, 1, 6);
        tests++; if (inj_l !== 32'h0 || ext_l !== 32'h0) begin fails++; $display("FAIL abort_lines: got inj %h ext %h want 0 0", inj_l, ext_l); end
        tests++; if (trg_l !== 32'h0 || done_l !== 32'h0) begin fails++; $display("FAIL abort_trg_done: got trg %h done %h want 0 0", trg_l, done_l); end
        tests++; if (busy_l !== 32'h0) begin fails++; $display("FAIL abort_busy: got %h want 00000000", busy_l); end
        tests++; if (PLS_SENT !== 12'd1) begin fails++; $display("FAIL abort_sent: got %0d want 1", PLS_SENT); end
        go(1, 0, 0, 1, 3);
        tests++; if (drop_l !== 32'h2 || inj_l !== 32'h0 || busy_l !== 32'h0) begin fails++; $display("FAIL abort_idle_start: got drop %h inj %h busy %h want 00000002 0 0", drop_l, inj_l, busy_l); end
    endtask

    task automatic test_async_reset;
        SW_SEL = 0; PLS_WIDTH = 8; TRG_DLY = 0;
        go(0, 1, 0, 0, 3);
        tests++; if (EXT_PULSE !== 1'b1 || BUSY !== 1'b1) begin fails++; $display("FAIL rst_pre: got ext %b busy %b want 1 1", EXT_PULSE, BUSY); end
        #2 RST_RESYNC = 1;
        #1;
        tests++; if (EXT_PULSE !== 1'b0 || BUSY !== 1'b0 || PLS_SENT !== 12'd0) begin fails++; $display("FAIL rst_async: got ext %b busy %b sent %0d want 0 0 0", EXT_PULSE, BUSY, PLS_SENT); end
        @(posedge CLK40); #1 RST_RESYNC = 0;
        BURST_LEN = 0;
        go(0, 0, 1, 0, 4);
        tests++; if (drop_l !== 32'h2) begin fails++; $display("FAIL len0_drop: got %h want 00000002", drop_l); end
        tests++; if ({inj_l, ext_l, trg_l, done_l, busy_l} !== '0) begin fails++; $display("FAIL len0_quiet: got inj %h ext %h trg %h done %h busy %h want all 0", inj_l, ext_l, trg_l, done_l, busy_l); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_burst;
        test_arbitration;
        test_trg_overrun;
        test_clamp;
        test_abort;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
